cam_cfg_sequencer: RTL and testbench

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

---
 rtl/cam_cfg_pkg.sv | 16 +
 rtl/cam_cfg_if.sv | 11 +
 rtl/cam_cfg_timer.sv | 18 +
 rtl/cam_cfg_sequencer.sv | 124 ++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: state encoding, microcontroller bus bit positions and chip-ID register addresses.
package cam_cfg_pkg;
  typedef enum logic [3:0] {
    IDLE, PWRUP, SETTLE, GO, WAIT_DONE, WAIT_RELEASE, CHECK, NEXT, FIN
  } state_t;
  localparam int IN_GO    = 0;
  localparam int IN_CAM   = 1;
  localparam int OUT_DONE = 0;
  localparam int OUT_NACK = 1;
  localparam logic [4:0] ADDR_ID_HI = 5'd0;
  localparam logic [4:0] ADDR_ID_LO = 5'd1;
  // a timer loaded with n-1 expires after n cycles; 0 behaves like 1
  function automatic logic [23:0] load_of(input logic [23:0] n);
    return (n == 24'd0) ? 24'd0 : n - 24'd1;
  endfunction
endpackage

// File: rtl/cam_cfg_if.sv
// cam_cfg_if: sequencer <-> I2C microcontroller bus (go/camera inputs, done/nack outputs, error flag, register read-back).
interface cam_cfg_if;
  logic [15:0] cpu_inputs;
  logic [15:0] cpu_outputs;
  logic        cpu_error;
  logic [4:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_write;
  modport master (output cpu_inputs, input cpu_outputs, cpu_error, reg_addr, reg_data, reg_write);
  modport slave  (input cpu_inputs, output cpu_outputs, cpu_error, reg_addr, reg_data, reg_write);
endinterface

// File: rtl/cam_cfg_timer.sv
// cam_cfg_timer: loadable down-counter that stops at zero; expired while the count is zero.
module cam_cfg_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign expired = (cnt == '0);
endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: powers up two cameras, then runs a go/done handshake with the I2C microcontroller per camera, with timeout and retry.
// Define CAM_CFG_ID_CHECK_EN to also reject a camera whose read-back chip ID differs from EXPECTED_ID.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [15:0] RST_CYCLES     = 16'd1024,
  parameter logic [15:0] SETTLE_CYCLES  = 16'd4096,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1048576,
  parameter logic [1:0]  MAX_RETRY      = 2'd2,
  parameter logic [15:0] EXPECTED_ID    = 16'h7670
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  cam_cfg_if.master   bus,
  output logic        i2c_sel,
  output logic [1:0]  cam_pwdn,
  output logic [1:0]  cam_rst_n,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fail,
  output logic [15:0] chip_id0,
  output logic [15:0] chip_id1
);
  localparam logic [15:0] RST_LD    = 16'(load_of(24'(RST_CYCLES)));
  localparam logic [15:0] SETTLE_LD = 16'(load_of(24'(SETTLE_CYCLES)));
  localparam logic [23:0] TO_LD     = load_of(TIMEOUT_CYCLES);
  state_t      state, nxt;
  logic        cam, sel_q, nack, err, abort, pass, id_ok;
  logic        rst_exp, settle_exp, to_exp;
  logic [1:0]  retry;
  logic [15:0] cur_id, wr_id;
  logic        unused_bits;
  assign unused_bits = ^{bus.cpu_outputs[15:2], EXPECTED_ID};
  // each timer is loaded on the edge that enters the state it times
  cam_cfg_timer #(.W(16)) u_rst_tmr (.clk(clk), .rst(rst), .load(nxt == PWRUP && state != PWRUP),
                                     .value(RST_LD), .expired(rst_exp));
  cam_cfg_timer #(.W(16)) u_settle_tmr (.clk(clk), .rst(rst), .load(nxt == SETTLE && state != SETTLE),
                                        .value(SETTLE_LD), .expired(settle_exp));
  cam_cfg_timer #(.W(24)) u_to_tmr (.clk(clk), .rst(rst), .load(nxt == GO && state != GO),
                                    .value(TO_LD), .expired(to_exp));
  assign cur_id = cam ? chip_id1 : chip_id0;
  assign wr_id  = (bus.reg_addr == ADDR_ID_HI) ? {bus.reg_data, cur_id[7:0]} : {cur_id[15:8], bus.reg_data};
`ifdef CAM_CFG_ID_CHECK_EN
  assign id_ok = (cur_id == EXPECTED_ID);
`else
  assign id_ok = 1'b1;
`endif
  assign pass      = !err && !nack && id_ok;
  assign busy      = !(state == IDLE || state == FIN);
  assign done      = (state == FIN);
  assign cam_pwdn  = (state == IDLE || state == PWRUP) ? 2'b11 : 2'b00;
  assign cam_rst_n = ~cam_pwdn;
  assign i2c_sel   = (state == GO) ? cam : sel_q;
  always_comb begin
    bus.cpu_inputs         = '0;
    bus.cpu_inputs[IN_GO]  = (state == GO || state == WAIT_DONE);
    bus.cpu_inputs[IN_CAM] = cam;
  end
  always_comb begin
    nxt   = state;
    abort = 1'b0;
    case (state)
      IDLE, FIN:    nxt = start ? PWRUP : state;
      PWRUP:        nxt = rst_exp ? SETTLE : PWRUP;
      SETTLE:       nxt = settle_exp ? GO : SETTLE;
      GO:           nxt = WAIT_DONE;
      WAIT_DONE: begin
        nxt   = bus.cpu_outputs[OUT_DONE] ? WAIT_RELEASE : (to_exp ? CHECK : WAIT_DONE);
        abort = !bus.cpu_outputs[OUT_DONE] && to_exp;
      end
      WAIT_RELEASE: begin
        nxt   = (!bus.cpu_outputs[OUT_DONE] || to_exp) ? CHECK : WAIT_RELEASE;
        abort = bus.cpu_outputs[OUT_DONE] && to_exp;
      end
      CHECK:        nxt = (pass || retry >= MAX_RETRY) ? NEXT : GO;
      NEXT:         nxt = cam ? FIN : GO;
      default:      nxt = IDLE;
    endcase
    if (bus.cpu_error && state inside {PWRUP, SETTLE, GO, WAIT_DONE, WAIT_RELEASE}) begin
      nxt   = CHECK;
      abort = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cam      <= 1'b0;
      sel_q    <= 1'b0;
      nack     <= 1'b0;
      err      <= 1'b0;
      retry    <= 2'd0;
      fail     <= 2'b00;
      chip_id0 <= 16'd0;
      chip_id1 <= 16'd0;
    end else begin
      state <= nxt;
      if (!busy && start) begin
        cam      <= 1'b0;
        retry    <= 2'd0;
        fail     <= 2'b00;
        chip_id0 <= 16'd0;
        chip_id1 <= 16'd0;
      end
      if (nxt == GO) begin
        nack <= 1'b0;
        err  <= 1'b0;
      end
      if (abort) err <= 1'b1;
      if (state == WAIT_DONE && nxt == WAIT_RELEASE) nack <= bus.cpu_outputs[OUT_NACK];
      if (state == GO) sel_q <= cam;
      if (state == CHECK && nxt == GO) retry <= retry + 2'd1;
      if (state == CHECK && nxt == NEXT && !pass) fail[cam] <= 1'b1;
      if (state == NEXT && !cam) begin
        cam   <= 1'b1;
        retry <= 2'd0;
      end
      if (busy && bus.reg_write && (bus.reg_addr == ADDR_ID_HI || bus.reg_addr == ADDR_ID_LO)) begin
        if (cam) chip_id1 <= wr_id;
        else chip_id0 <= wr_id;
      end
    end
  end
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: directed and randomized runs of cam_cfg_sequencer against a microcontroller model and an outcome-level reference.
`timescale 1ns/1ps
module tb_cam_cfg_sequencer;
  localparam logic [15:0] RST_C  = 16'd20;
  localparam logic [15:0] SET_C  = 16'd30;
  localparam logic [23:0] TO_C   = 24'd100;
  localparam int          MR     = 2;
  localparam logic [15:0] EXP_ID = 16'h7670;
`ifdef CAM_CFG_ID_CHECK_EN
  localparam bit ID_CHK = 1'b1;
`else
  localparam bit ID_CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic i2c_sel, busy, done;
  logic [1:0] cam_pwdn, cam_rst_n, fail;
  logic [15:0] chip_id0, chip_id1;
  cam_cfg_if bus();
  cam_cfg_sequencer #(.RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .TIMEOUT_CYCLES(TO_C),
                      .MAX_RETRY(2'(MR)), .EXPECTED_ID(EXP_ID)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .i2c_sel(i2c_sel), .cam_pwdn(cam_pwdn),
    .cam_rst_n(cam_rst_n), .busy(busy), .done(done), .fail(fail), .chip_id0(chip_id0), .chip_id1(chip_id1));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  // per camera, per attempt behaviour of the microcontroller: kind 0 = answers, 1 = hangs, 2 = raises cpu_error
  int          plan_kind [2][4];
  logic        plan_nack [2][4];
  logic [15:0] plan_id   [2][4];
  int          plan_delay[2][4];
  int          att[2], go_cnt[2];
  logic        sel_log[$];
  int          exp_go[2];
  logic [1:0]  exp_fail;
  logic [15:0] exp_id[2];
  initial begin
    int c, a;
    bit live;
    bus.cpu_outputs = '0; bus.cpu_error = 1'b0; bus.reg_write = 1'b0; bus.reg_addr = '0; bus.reg_data = '0;
    forever begin
      do @(negedge clk); while (bus.cpu_inputs[0] !== 1'b1);
      c = int'(bus.cpu_inputs[1]);
      a = (att[c] > 3) ? 3 : att[c];
      att[c]++; go_cnt[c]++;
      sel_log.push_back(i2c_sel);
      live = 1'b1;
      if (plan_kind[c][a] != 1) begin
        for (int i = 0; i < plan_delay[c][a] && live; i++) begin
          @(negedge clk);
          live = bus.cpu_inputs[0];
        end
        if (live && plan_kind[c][a] == 2) begin
          bus.cpu_error = 1'b1;
          @(negedge clk);
          bus.cpu_error = 1'b0;
        end else if (live) begin
          bus.reg_write = 1'b1; bus.reg_addr = 5'd0; bus.reg_data = plan_id[c][a][15:8];
          @(negedge clk);
          bus.reg_addr = 5'd1; bus.reg_data = plan_id[c][a][7:0];
          @(negedge clk);
          bus.reg_write = 1'b0;
          bus.cpu_outputs = {14'd0, plan_nack[c][a], 1'b1};
        end
      end
      for (int i = 0; i < 5000 && bus.cpu_inputs[0]; i++) @(negedge clk);
      bus.cpu_outputs = '0;
    end
  end
  task automatic set_plan(input int kind, input bit nack, input logic [15:0] id, input int dly);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 4; a++) begin
        plan_kind[c][a] = kind; plan_nack[c][a] = nack; plan_id[c][a] = id; plan_delay[c][a] = dly;
      end
  endtask
  // reference: a camera passes on its first clean attempt, otherwise fails after MR+1 attempts
  task automatic ref_eval();
    for (int c = 0; c < 2; c++) begin
      exp_go[c] = 0; exp_fail[c] = 1'b1; exp_id[c] = 16'd0;
      for (int a = 0; a <= MR; a++) begin
        exp_go[c]++;
        if (plan_kind[c][a] == 0) exp_id[c] = plan_id[c][a];
        if (plan_kind[c][a] == 0 && !plan_nack[c][a] && (!ID_CHK || plan_id[c][a] == EXP_ID)) begin
          exp_fail[c] = 1'b0;
          break;
        end
      end
    end
  endtask
  function automatic int sel_bad();
    int n = (sel_log.size() != exp_go[0] + exp_go[1]) ? 1 : 0;
    foreach (sel_log[i]) if (sel_log[i] !== (i >= exp_go[0])) n++;
    return n;
  endfunction
  task automatic kick();
    att[0] = 0; att[1] = 0; go_cnt[0] = 0; go_cnt[1] = 0; sel_log.delete();
    ref_eval();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (done === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask
  task automatic do_run(output bit ok);
    kick();
    wait_done(ok);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cpu_inputs, i2c_sel, cam_pwdn, cam_rst_n, busy, done, fail} !== {16'd0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00})
      begin errors++; $display("FAIL reset_ctrl: got %h expected %h", {bus.cpu_inputs, i2c_sel, cam_pwdn, cam_rst_n, busy, done, fail}, {16'd0, 1'b0, 2'b11, 2'b00, 4'b0000}); end
    checks++;
    if ({chip_id0, chip_id1} !== 32'd0) begin errors++; $display("FAIL reset_ids: got %h expected 0", {chip_id0, chip_id1}); end
    rst = 1'b0;
  endtask
  task automatic test_power_timing();
    int n;
    bit ok;
    set_plan(0, 1'b0, EXP_ID, 47);
    kick();
    n = 0;
    while (busy && cam_pwdn == 2'b11 && n < 1000) begin n++; @(negedge clk); end
    checks++; if (n != int'(RST_C)) begin errors++; $display("FAIL pwrup_cycles: got %0d expected %0d", n, RST_C); end
    checks++; if ({cam_pwdn, cam_rst_n} !== 4'b0011) begin errors++; $display("FAIL released_pins: got %b expected 0011", {cam_pwdn, cam_rst_n}); end
    n = 0;
    while (bus.cpu_inputs[0] !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
    checks++; if (n != int'(SET_C)) begin errors++; $display("FAIL settle_cycles: got %0d expected %0d", n, SET_C); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL power_done: got 0 expected 1"); end
    checks++; if (fail !== exp_fail) begin errors++; $display("FAIL power_fail: got %b expected %b", fail, exp_fail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL power_busy: got %b expected 0", busy); end
    checks++; if (sel_bad() != 0) begin errors++; $display("FAIL power_sel_seq: got %0d pulses expected %0d then %0d", sel_log.size(), exp_go[0], exp_go[1]); end
    checks++; if ({chip_id0, chip_id1} !== {exp_id[0], exp_id[1]}) begin errors++; $display("FAIL power_ids: got %h expected %h", {chip_id0, chip_id1}, {exp_id[0], exp_id[1]}); end
  endtask
  task automatic test_nack_retry();
    bit ok;
    set_plan(0, 1'b0, EXP_ID, 20);
    for (int a = 0; a < 4; a++) plan_nack[1][a] = 1'b1;
    do_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_done: got 0 expected 1"); end
    checks++; if (fail !== 2'b10) begin errors++; $display("FAIL nack_fail: got %b expected 10", fail); end
    checks++; if (go_cnt[1] != 3) begin errors++; $display("FAIL nack_go_cam1: got %0d expected 3", go_cnt[1]); end
    checks++; if (go_cnt[0] != exp_go[0]) begin errors++; $display("FAIL nack_go_cam0: got %0d expected %0d", go_cnt[0], exp_go[0]); end
    checks++; if (sel_bad() != 0) begin errors++; $display("FAIL nack_sel_seq: got %0d pulses expected %0d then %0d", sel_log.size(), exp_go[0], exp_go[1]); end
  endtask
  task automatic test_timeout();
    int n;
    bit ok;
    set_plan(1, 1'b0, EXP_ID, 10);
    kick();
    n = 0;
    while (bus.cpu_inputs[0] !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
    n = 0;
    while (bus.cpu_inputs[0] === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    checks++; if (n != int'(TO_C)) begin errors++; $display("FAIL timeout_go_len: got %0d expected %0d", n, TO_C); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done: got 0 expected 1"); end
    checks++; if (fail !== 2'b11) begin errors++; $display("FAIL timeout_fail: got %b expected 11", fail); end
    checks++; if (go_cnt[0] + go_cnt[1] != 6) begin errors++; $display("FAIL timeout_go_total: got %0d expected 6", go_cnt[0] + go_cnt[1]); end
  endtask
  task automatic test_reset_mid();
    int n;
    bit ok;
    set_plan(0, 1'b0, EXP_ID, 47);
    kick();
    n = 0;
    while (bus.cpu_inputs[0] !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cpu_inputs, cam_pwdn, cam_rst_n, busy, done, fail, i2c_sel} !== {16'd0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0})
      begin errors++; $display("FAIL midreset_outputs: got %h expected %h", {bus.cpu_inputs, cam_pwdn, cam_rst_n, busy, done, fail, i2c_sel}, {16'd0, 2'b11, 2'b00, 5'd0}); end
    rst = 1'b0;
    do_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_rerun_done: got 0 expected 1"); end
    checks++; if (fail !== 2'b00) begin errors++; $display("FAIL midreset_fail: got %b expected 00", fail); end
    checks++; if (go_cnt[0] != 1 || go_cnt[1] != 1) begin errors++; $display("FAIL midreset_go: got %0d/%0d expected 1/1", go_cnt[0], go_cnt[1]); end
    checks++; if ({chip_id0, chip_id1} !== {EXP_ID, EXP_ID}) begin errors++; $display("FAIL midreset_ids: got %h expected %h", {chip_id0, chip_id1}, {EXP_ID, EXP_ID}); end
  endtask
  task automatic test_id_check();
    bit ok;
    set_plan(0, 1'b0, EXP_ID, 15);
    for (int a = 0; a < 4; a++) plan_id[0][a] = 16'h7673;
    do_run(ok);
    checks++; if (!ok) begin errors++; $display("FAIL id_done: got 0 expected 1"); end
    checks++; if (fail !== exp_fail) begin errors++; $display("FAIL id_fail: got %b expected %b", fail, exp_fail); end
    checks++; if (go_cnt[0] != exp_go[0]) begin errors++; $display("FAIL id_go_cam0: got %0d expected %0d", go_cnt[0], exp_go[0]); end
    checks++; if (chip_id0 !== 16'h7673) begin errors++; $display("FAIL id_chip0: got %h expected 7673", chip_id0); end
    checks++; if (chip_id1 !== EXP_ID) begin errors++; $display("FAIL id_chip1: got %h expected %h", chip_id1, EXP_ID); end
  endtask
  task automatic test_random();
    bit ok;
    int r;
    for (int run = 0; run < 8; run++) begin
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 4; a++) begin
          r = int'($urandom_range(0, 7));
          plan_kind[c][a]  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
          plan_nack[c][a]  = ($urandom_range(0, 3) == 0);
          plan_id[c][a]    = ($urandom_range(0, 3) == 0) ? (EXP_ID ^ 16'($urandom_range(1, 255))) : EXP_ID;
          plan_delay[c][a] = int'($urandom_range(3, 60));
        end
      do_run(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: got 0 expected 1", run); end
      checks++; if (fail !== exp_fail) begin errors++; $display("FAIL rand%0d_fail: got %b expected %b", run, fail, exp_fail); end
      checks++; if (go_cnt[0] != exp_go[0]) begin errors++; $display("FAIL rand%0d_go0: got %0d expected %0d", run, go_cnt[0], exp_go[0]); end
      checks++; if (go_cnt[1] != exp_go[1]) begin errors++; $display("FAIL rand%0d_go1: got %0d expected %0d", run, go_cnt[1], exp_go[1]); end
      checks++; if (chip_id0 !== exp_id[0]) begin errors++; $display("FAIL rand%0d_id0: got %h expected %h", run, chip_id0, exp_id[0]); end
      checks++; if (chip_id1 !== exp_id[1]) begin errors++; $display("FAIL rand%0d_id1: got %h expected %h", run, chip_id1, exp_id[1]); end
      checks++; if (sel_bad() != 0) begin errors++; $display("FAIL rand%0d_sel_seq: got %0d pulses expected %0d then %0d", run, sel_log.size(), exp_go[0], exp_go[1]); end
    end
  endtask
  initial begin
    test_reset();
    test_power_timing();
    test_nack_retry();
    test_timeout();
    test_reset_mid();
    test_id_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
